priority_grant_decoder: RTL and testbench

- Consumes the encoded winner index produced by the priority selection logic.
- Drives one one-hot grant line back to the selected requester and holds it until that requester signals done or a hold timeout expires.
- Enforces a fixed idle gap before it accepts the next selection.
- Sits between the priority selector and the requester channels; it is the decode/response end of the request path.

---
 rtl/priority_grant_decoder_pkg.sv | 18 +
 rtl/priority_grant_decoder_grant_hold_timer.sv | 37 +++
 rtl/priority_grant_decoder.sv | 138 +++++++++++++
 tb/tb_priority_grant_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_grant_decoder_pkg.sv
// Shared definitions for the priority request path: decoder state encoding and
// counter width helper, also used on the priority selector side.
package priority_grant_decoder_pkg;

    typedef logic [1:0] pgd_state_t;

    localparam pgd_state_t StIdle  = 2'd0;
    localparam pgd_state_t StGrant = 2'd1;
    localparam pgd_state_t StGap   = 2'd2;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/priority_grant_decoder_grant_hold_timer.sv
// Saturating up-counter with synchronous clear and an expire flag that is
// high while the count equals the supplied limit.
module priority_grant_decoder_grant_hold_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [Width-1:0] limit_i,
    output logic             expire_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == limit_i);

    // Clear has priority; counting stops once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/priority_grant_decoder.sv
// Decodes the winning index from the priority selector into a one-hot grant,
// holds it until the owner reports done or the hold limit expires, then keeps
// an idle gap before accepting the next selection.
module priority_grant_decoder
    import priority_grant_decoder_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned HOLD_MAX   = 15,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_valid,
    input  logic [IDX_W-1:0] sel_idx,
    output logic             sel_ready,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     grant,
    output logic             busy,
    output logic             timeout,
    output logic             err_idx
);

    localparam int unsigned HoldW = cnt_width(HOLD_MAX);
    localparam int unsigned GapW  = cnt_width(GAP_CYCLES);

    pgd_state_t   state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic         timeout_q, timeout_d;
    logic         err_q, err_d;

    logic accept;
    logic idx_ok;
    logic done_hit;
    logic release_grant;
    logic hold_clear, hold_en, hold_expire;
    logic gap_clear, gap_en, gap_expire;

    assign sel_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign grant     = grant_q;
    assign timeout   = timeout_q;
    assign err_idx   = err_q;

    assign accept = sel_valid && sel_ready;
    // Compare at 32 bits so N == 2**IDX_W still works.
    assign idx_ok = (32'(sel_idx) < N);

    // Masking with the held grant ignores done from non-granted channels.
    assign done_hit      = (state_q == StGrant) && |(done & grant_q);
    assign release_grant = (state_q == StGrant) && (done_hit || hold_expire);

    // Hold count steps on the accept edge too, so it reads 1 in the first
    // grant cycle and expires in grant cycle HOLD_MAX.
    assign hold_en    = (state_q == StGrant) || (accept && idx_ok);
    assign hold_clear = !hold_en;

    // Gap count likewise starts on the release edge and expires in the last
    // gap cycle.
    assign gap_en    = (state_q == StGap) || release_grant;
    assign gap_clear = !gap_en;

    priority_grant_decoder_grant_hold_timer #(
        .Width (HoldW)
    ) u_hold_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (hold_clear),
        .en_i     (hold_en),
        .limit_i  (HoldW'(HOLD_MAX)),
        .expire_o (hold_expire)
    );

    priority_grant_decoder_grant_hold_timer #(
        .Width (GapW)
    ) u_gap_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (gap_clear),
        .en_i     (gap_en),
        .limit_i  (GapW'(GAP_CYCLES)),
        .expire_o (gap_expire)
    );

    // Next-state, grant and pulse decode.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (idx_ok) begin
                        grant_d = N'(1) << sel_idx;
                        state_d = StGrant;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGrant: begin
                if (release_grant) begin
                    grant_d   = '0;
                    // done wins over a simultaneous expiry.
                    timeout_d = !done_hit;
                    state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                grant_d = '0;
                if (gap_expire) begin
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Directed bench: stimulus pushes the expected outputs of each cycle into a
// scoreboard queue, a negedge monitor pops and compares against the DUT.
// Instance a_ uses GAP_CYCLES=1, instance b_ uses GAP_CYCLES=0.
module tb_priority_grant_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_sel_valid, b_sel_valid;
    logic [1:0] a_sel_idx, b_sel_idx;
    logic [2:0] a_done, b_done;
    logic       a_sel_ready, b_sel_ready;
    logic [2:0] a_grant, b_grant;
    logic       a_busy, b_busy;
    logic       a_timeout, b_timeout;
    logic       a_err_idx, b_err_idx;

    priority_grant_decoder #(
        .N          (3),
        .IDX_W      (2),
        .HOLD_MAX   (15),
        .GAP_CYCLES (1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (a_sel_valid),
        .sel_idx   (a_sel_idx),
        .sel_ready (a_sel_ready),
        .done      (a_done),
        .grant     (a_grant),
        .busy      (a_busy),
        .timeout   (a_timeout),
        .err_idx   (a_err_idx)
    );

    priority_grant_decoder #(
        .N          (3),
        .IDX_W      (2),
        .HOLD_MAX   (15),
        .GAP_CYCLES (0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (b_sel_valid),
        .sel_idx   (b_sel_idx),
        .sel_ready (b_sel_ready),
        .done      (b_done),
        .grant     (b_grant),
        .busy      (b_busy),
        .timeout   (b_timeout),
        .err_idx   (b_err_idx)
    );

    typedef struct packed {
        logic       which;
        logic [2:0] grant;
        logic       busy;
        logic       ready;
        logic       tmo;
        logic       err;
    } exp_t;

    exp_t        sb[$];
    string       tq[$];
    string       tag;
    logic        cur;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    exp_t       mon_x;
    string      mon_tag;
    logic [6:0] mon_act, mon_req;

    // Monitor: compare one expected record per cycle, away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x   = sb.pop_front();
            mon_tag = tq.pop_front();
            mon_req = {mon_x.grant, mon_x.busy, mon_x.ready, mon_x.tmo, mon_x.err};
            if (mon_x.which)
                mon_act = {b_grant, b_busy, b_sel_ready, b_timeout, b_err_idx};
            else
                mon_act = {a_grant, a_busy, a_sel_ready, a_timeout, a_err_idx};
            n_vec++;
            if (mon_act !== mon_req) begin
                n_err++;
                $display("FAIL %s vec %0d gap%0d: {grant,busy,ready,timeout,err_idx} got %b required %b",
                         mon_tag, n_vec, mon_x.which ? 0 : 1, mon_act, mon_req);
            end
        end
    end

    // One cycle: drive inputs for the coming edge, expect outputs of this cycle.
    task automatic cyc(input logic v, input logic [1:0] idx, input logic [2:0] dn,
                       input logic [2:0] g, input logic b, input logic r,
                       input logic t, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        if (cur) begin
            b_sel_valid = v; b_sel_idx = idx; b_done = dn;
            a_sel_valid = 1'b0; a_sel_idx = 2'd0; a_done = 3'b000;
        end else begin
            a_sel_valid = v; a_sel_idx = idx; a_done = dn;
            b_sel_valid = 1'b0; b_sel_idx = 2'd0; b_done = 3'b000;
        end
        x.which = cur;
        x.grant = g;
        x.busy  = b;
        x.ready = r;
        x.tmo   = t;
        x.err   = e;
        sb.push_back(x);
        tq.push_back(tag);
    endtask

    task automatic idle_c();
        cyc(1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic acc(input logic [1:0] idx);
        cyc(1'b1, idx, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic hold(input logic [2:0] g, input logic [2:0] dn);
        cyc(1'b0, 2'd0, dn, g, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic gap_c();
        cyc(1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cur = 1'b0;
        a_sel_valid = 1'b0; a_sel_idx = 2'd0; a_done = 3'b000;
        b_sel_valid = 1'b0; b_sel_idx = 2'd0; b_done = 3'b000;

        tag = "reset";
        idle_c();
        idle_c();
        rst = 1'b0;

        tag = "basic";
        acc(2'd1);
        hold(3'b010, 3'b000);
        // selection presented during a grant must be ignored
        cyc(1'b1, 2'd0, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(3'b010, 3'b000);
        hold(3'b010, 3'b010);
        gap_c();
        idle_c();

        tag = "timeout";
        acc(2'd2);
        for (int i = 0; i < 15; i++) hold(3'b100, 3'b000);
        cyc(1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_c();

        tag = "collision";
        acc(2'd0);
        for (int i = 0; i < 14; i++) hold(3'b001, 3'b000);
        hold(3'b001, 3'b001);
        gap_c();
        idle_c();

        tag = "wrong_done";
        acc(2'd0);
        hold(3'b001, 3'b100);
        hold(3'b001, 3'b010);
        hold(3'b001, 3'b110);
        hold(3'b001, 3'b001);
        gap_c();
        idle_c();

        tag = "illegal_idx";
        acc(2'd3);
        cyc(1'b1, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        hold(3'b001, 3'b001);
        gap_c();
        idle_c();

        tag = "reset_mid";
        acc(2'd1);
        hold(3'b010, 3'b000);
        hold(3'b010, 3'b000);
        hold(3'b010, 3'b000);
        rst = 1'b1;
        idle_c();
        rst = 1'b0;
        idle_c();

        tag = "gap0_b2b";
        cur = 1'b1;
        acc(2'd2);
        cyc(1'b1, 2'd0, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
        acc(2'd0);
        hold(3'b001, 3'b001);
        idle_c();

        tag = "gap0_timeout";
        acc(2'd1);
        for (int i = 0; i < 15; i++) hold(3'b010, 3'b000);
        cyc(1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_c();

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
